// File: rtl/determinante_nxn_seq.sv
// Sequential determinant engine for 2x2/3x3/4x4 signed matrices.
// The engine sums the 24 signed permutation products of a 4x4 matrix with one shared multiplier.
module determinante_nxn_seq #(
    parameter int DATA_W = 8,
    parameter int DET_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            size,
    input  logic [16*DATA_W-1:0]  matriz,
    output logic [DET_W-1:0]      det,
    output logic                  done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  err
);

    localparam int PROD_W = 4 * DATA_W;
    localparam int ACC_W  = PROD_W + 5;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DET_W+1){1'b0}}, {(DET_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DET_W+1){1'b1}}, {(DET_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]       ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    // Column chosen in rows 0..3, two bits each, row 0 in the MSBs.
    function automatic logic [7:0] perm_rom(input logic [4:0] t);
        case (t)
            5'd0:    perm_rom = 8'b00_01_10_11;
            5'd1:    perm_rom = 8'b00_01_11_10;
            5'd2:    perm_rom = 8'b00_10_01_11;
            5'd3:    perm_rom = 8'b00_10_11_01;
            5'd4:    perm_rom = 8'b00_11_01_10;
            5'd5:    perm_rom = 8'b00_11_10_01;
            5'd6:    perm_rom = 8'b01_00_10_11;
            5'd7:    perm_rom = 8'b01_00_11_10;
            5'd8:    perm_rom = 8'b01_10_00_11;
            5'd9:    perm_rom = 8'b01_10_11_00;
            5'd10:   perm_rom = 8'b01_11_00_10;
            5'd11:   perm_rom = 8'b01_11_10_00;
            5'd12:   perm_rom = 8'b10_00_01_11;
            5'd13:   perm_rom = 8'b10_00_11_01;
            5'd14:   perm_rom = 8'b10_01_00_11;
            5'd15:   perm_rom = 8'b10_01_11_00;
            5'd16:   perm_rom = 8'b10_11_00_01;
            5'd17:   perm_rom = 8'b10_11_01_00;
            5'd18:   perm_rom = 8'b11_00_01_10;
            5'd19:   perm_rom = 8'b11_00_10_01;
            5'd20:   perm_rom = 8'b11_01_00_10;
            5'd21:   perm_rom = 8'b11_01_10_00;
            5'd22:   perm_rom = 8'b11_10_00_01;
            5'd23:   perm_rom = 8'b11_10_01_00;
            default: perm_rom = 8'b00_01_10_11;
        endcase
    endfunction

    // Permutation parity as the parity of its inversion count (1 = odd).
    function automatic logic perm_parity(input logic [7:0] p);
        logic par;
        par = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                par = par ^ (p[7-2*i -: 2] > p[7-2*j -: 2]);
            end
        end
        return par;
    endfunction

    state_t                    state_r, state_next_s;
    logic signed [DATA_W-1:0]  m_r [16];
    logic signed [DATA_W-1:0]  pad_s [16];
    logic                      err_pend_r;
    logic [4:0]                t_r;
    logic [1:0]                s_r;
    logic signed [PROD_W-1:0]  prod_r, prod_next_s;
    logic signed [ACC_W-1:0]   acc_r, prod_ext_s;
    logic [7:0]                perm_s;
    logic [1:0]                col_s;
    logic signed [DATA_W-1:0]  factor_s;
    logic                      accept_s, last_s;
    logic [DET_W-1:0]          sat_det_s;
    logic                      sat_ovf_s;
    logic [DET_W-1:0]          det_r;
    logic                      done_r, busy_r, ovf_r, err_r;

    assign accept_s = start & ~busy_r;
    assign last_s   = (state_r == RUN) && (t_r == 5'd23) && (s_r == 2'd3);
    assign perm_s   = perm_rom(t_r);

    // Unused rows/columns become identity so every size runs the 4x4 datapath.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if ((size == 2'd2 && (r >= 2 || c >= 2)) || (size == 2'd3 && (r == 3 || c == 3))) begin
                    pad_s[4*r+c] = (r == c) ? ONE : '0;
                end else begin
                    pad_s[4*r+c] = matriz[(15-(4*r+c))*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Operand selection and the running product of the current term.
    always_comb begin
        case (s_r)
            2'd0:    col_s = perm_s[7:6];
            2'd1:    col_s = perm_s[5:4];
            2'd2:    col_s = perm_s[3:2];
            2'd3:    col_s = perm_s[1:0];
            default: col_s = 2'd0;
        endcase
        factor_s = m_r[{s_r, col_s}];
        if (s_r == 2'd0) begin
            prod_next_s = {{(PROD_W-DATA_W){factor_s[DATA_W-1]}}, factor_s};
        end else begin
            prod_next_s = prod_r * factor_s;
        end
        prod_ext_s = {{(ACC_W-PROD_W){prod_next_s[PROD_W-1]}}, prod_next_s};
    end

    // Clamp the accumulator into the signed DET_W output range.
    always_comb begin
        if (acc_r > ACC_MAX) begin
            sat_det_s = {1'b0, {(DET_W-1){1'b1}}};
            sat_ovf_s = 1'b1;
        end else if (acc_r < ACC_MIN) begin
            sat_det_s = {1'b1, {(DET_W-1){1'b0}}};
            sat_ovf_s = 1'b1;
        end else begin
            sat_det_s = acc_r[DET_W-1:0];
            sat_ovf_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Next-state logic; FIN accepts a new request because busy is already low.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, FIN: begin
                if (accept_s) state_next_s = (size == 2'd1) ? FIN : RUN;
                else          state_next_s = IDLE;
            end
            RUN: begin
                if (last_s) state_next_s = FIN;
                else        state_next_s = RUN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, term/step counters, product and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_r[i] <= '0;
            err_pend_r <= 1'b0;
            t_r        <= 5'd0;
            s_r        <= 2'd0;
            prod_r     <= '0;
            acc_r      <= '0;
            busy_r     <= 1'b0;
        end else if (accept_s) begin
            m_r        <= pad_s;
            err_pend_r <= (size == 2'd1);
            t_r        <= 5'd0;
            s_r        <= 2'd0;
            prod_r     <= '0;
            acc_r      <= '0;
            busy_r     <= (size != 2'd1);
        end else if (state_r == RUN) begin
            s_r    <= s_r + 2'd1;
            prod_r <= prod_next_s;
            if (s_r == 2'd3) begin
                t_r   <= t_r + 5'd1;
                acc_r <= perm_parity(perm_s) ? acc_r - prod_ext_s : acc_r + prod_ext_s;
            end
            if (last_s) busy_r <= 1'b0;
        end
    end

    // Result registers, loaded only while in FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_r  <= '0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= (state_r == FIN);
            if (state_r == FIN) begin
                det_r <= err_pend_r ? '0 : sat_det_s;
                ovf_r <= err_pend_r ? 1'b0 : sat_ovf_s;
                err_r <= err_pend_r;
            end
        end
    end

    assign det      = det_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign overflow = ovf_r;
    assign err      = err_r;

endmodule

// File: tb/tb_determinante_nxn_seq.sv
// Directed bench for determinante_nxn_seq: DET_W=32 and DET_W=16 instances share one stimulus.
module tb_determinante_nxn_seq;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   size;
    logic [127:0] matriz;
    logic [31:0]  det;
    logic [15:0]  det16;
    logic         done, busy, overflow, err;
    logic         done16, busy16, ovf16, err16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    determinante_nxn_seq #(.DATA_W(8), .DET_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .matriz(matriz),
        .det(det), .done(done), .busy(busy), .overflow(overflow), .err(err)
    );

    determinante_nxn_seq #(.DATA_W(8), .DET_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .size(size), .matriz(matriz),
        .det(det16), .done(done16), .busy(busy16), .overflow(ovf16), .err(err16)
    );

    typedef struct {
        logic [1:0]   sz;
        logic [127:0] m;
        longint       d32;
        logic         o32;
        longint       d16;
        logic         o16;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] rw(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[7:0]};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic accept(input logic [1:0] sz, input logic [127:0] m);
        @(negedge clk);
        size = sz; matriz = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; matriz = ~m; size = ~sz;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int n;
        accept(v.sz, v.m);
        wait_done(n);
        chk($sformatf("v%0d lat", k), n, v.lat);
        chk($sformatf("v%0d det", k), $signed(det), v.d32);
        chk($sformatf("v%0d ovf", k), overflow, v.o32);
        chk($sformatf("v%0d err", k), err, v.e);
        chk($sformatf("v%0d det16", k), $signed(det16), v.d16);
        chk($sformatf("v%0d ovf16", k), ovf16, v.o16);
        chk($sformatf("v%0d err16", k), err16, v.e);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pulse", k), done, 0);
    endtask

    initial begin
        int n, pulses;
        logic [127:0] ident;
        ident = {rw(1,0,0,0), rw(0,1,0,0), rw(0,0,1,0), rw(0,0,0,1)};

        vecs[0]  = '{2'd0, ident, 1, 1'b0, 1, 1'b0, 1'b0, 97};
        vecs[1]  = '{2'd2, {rw(3,8,99,-7), rw(4,6,5,12), rw(11,-3,77,2), rw(-9,1,4,100)},
                     -14, 1'b0, -14, 1'b0, 1'b0, 97};
        vecs[2]  = '{2'd3, {rw(6,1,1,55), rw(4,-2,5,-9), rw(2,8,7,3), rw(13,-128,127,0)},
                     -306, 1'b0, -306, 1'b0, 1'b0, 97};
        vecs[3]  = '{2'd0, {4{rw(-128,-128,-128,-128)}}, 0, 1'b0, 0, 1'b0, 1'b0, 97};
        vecs[4]  = '{2'd0, {rw(-128,0,0,0), rw(0,-128,0,0), rw(0,0,-128,0), rw(0,0,0,-128)},
                     268435456, 1'b0, 32767, 1'b1, 1'b0, 97};
        vecs[5]  = '{2'd0, {rw(16,0,0,0), rw(0,16,0,0), rw(0,0,16,0), rw(0,0,0,16)},
                     65536, 1'b0, 32767, 1'b1, 1'b0, 97};
        vecs[6]  = '{2'd0, {rw(-16,0,0,0), rw(0,16,0,0), rw(0,0,16,0), rw(0,0,0,16)},
                     -65536, 1'b0, -32768, 1'b1, 1'b0, 97};
        vecs[7]  = '{2'd1, ident, 0, 1'b0, 0, 1'b0, 1'b1, 1};
        vecs[8]  = '{2'd2, {rw(2,1,-5,6), rw(1,3,7,8), rw(9,9,9,9), rw(1,2,3,4)},
                     5, 1'b0, 5, 1'b0, 1'b0, 97};
        vecs[9]  = '{2'd0, {rw(1,2,0,0), rw(3,4,0,0), rw(0,0,5,6), rw(0,0,7,8)},
                     4, 1'b0, 4, 1'b0, 1'b0, 97};
        vecs[10] = '{2'd0, {rw(0,0,0,2), rw(0,0,3,0), rw(0,4,0,0), rw(5,0,0,0)},
                     120, 1'b0, 120, 1'b0, 1'b0, 97};
        vecs[11] = '{2'd0, {rw(0,1,0,0), rw(1,0,0,0), rw(0,0,1,0), rw(0,0,0,1)},
                     -1, 1'b0, -1, 1'b0, 1'b0, 97};

        rst = 1'b0; start = 1'b0; size = 2'd0; matriz = '0;
        #2 rst = 1'b1;
        #20;
        chk("rst det", det, 0);
        chk("rst done", done, 0);
        chk("rst busy", busy, 0);
        chk("rst ovf", overflow, 0);
        chk("rst err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);

        // A start pulse at cycle 10 of a run must be ignored.
        accept(vecs[1].sz, vecs[1].m);
        repeat (9) @(posedge clk);
        #1;
        chk("busy mid run", busy, 1);
        @(negedge clk);
        start = 1'b1; size = 2'd0; matriz = ident;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignored lat", n, 97 - 10);
        chk("ignored det", $signed(det), -14);

        // A start during FIN is accepted back-to-back.
        @(posedge clk);
        accept(2'd0, ident);
        repeat (96) @(posedge clk);
        #1;
        chk("fin busy", busy, 0);
        chk("fin done", done, 0);
        @(negedge clk);
        start = 1'b1; size = vecs[8].sz; matriz = vecs[8].m;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("fin done rise", done, 1);
        chk("fin det first", $signed(det), 1);
        chk("fin busy again", busy, 1);
        @(posedge clk);
        #1;
        wait_done(n);
        chk("b2b lat", n + 1, 97);
        chk("b2b det", $signed(det), 5);

        // Reset at cycle 50 of a run: outputs clear at once and no done follows.
        @(posedge clk);
        run_vec(106, vecs[6]);
        accept(vecs[9].sz, vecs[9].m);
        repeat (49) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid rst det", det, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst done", done, 0);
        chk("mid rst ovf16", ovf16, 0);
        chk("mid rst det16", det16, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        chk("no done after rst", pulses, 0);
        run_vec(109, vecs[9]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
